// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register mode muxes and their sequencer.
// Both the mux consumer and usr_mode_sequencer import this, so the select encoding cannot drift.
package usr_pkg;

   localparam int USR_WIDTH_LEN = 2;
   localparam int USR_DATA_W    = 4;
   localparam int USR_CNT_W     = 3;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } seq_state_e;

endpackage

// File: rtl/usr_cmd_buf.sv
// One-entry command holding register, used by usr_mode_sequencer when USR_SEQ_CMDBUF_EN is defined.
// It lets a command arrive while another one is still driving the muxes.
module usr_cmd_buf
   import usr_pkg::*;
#(
   parameter int DATA_W = USR_DATA_W,
   parameter int CNT_W  = USR_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [1:0]        in_op,
   input  logic [CNT_W-1:0]  in_cnt,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sin,
   output logic              full,
   output logic [1:0]        out_op,
   output logic [CNT_W-1:0]  out_cnt,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sin
);

   // push only happens while empty and pop only while full, so they never collide
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full     <= 1'b0;
         out_op   <= MODE_HOLD;
         out_cnt  <= '0;
         out_data <= '0;
         out_sin  <= 1'b0;
      end else begin
         if (pop) begin
            full <= 1'b0;
         end
         if (push) begin
            full     <= 1'b1;
            out_op   <= in_op;
            out_cnt  <= in_cnt;
            out_data <= in_data;
            out_sin  <= in_sin;
         end
      end
   end

endmodule

// File: rtl/usr_mode_sequencer.sv
// Command sequencer driving mode select, serial fill bits and load word of the 4-bit universal shift register.
// Define USR_SEQ_CMDBUF_EN to add a one-entry command buffer for gap-free back-to-back commands.
module usr_mode_sequencer
   import usr_pkg::*;
#(
   parameter int WIDTH_LEN = USR_WIDTH_LEN,
   parameter int DATA_W    = USR_DATA_W,
   parameter int CNT_W     = USR_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [CNT_W-1:0]     cmd_cnt,
   input  logic [DATA_W-1:0]    cmd_data,
   input  logic                 cmd_sin,
   output logic [WIDTH_LEN-1:0] sel,
   output logic                 sr_in,
   output logic                 sl_in,
   output logic [DATA_W-1:0]    par_data,
   output logic                 busy,
   output logic                 done
);

   seq_state_e        state;
   logic [CNT_W-1:0]  cnt_q;

   logic              accept;
   logic              take;
   logic              free;
   logic              finishing;
   logic              zero_len;
   logic [1:0]        nxt_op;
   logic [CNT_W-1:0]  nxt_cnt;
   logic [DATA_W-1:0] nxt_data;
   logic              nxt_sin;

   seq_state_e        start_state;
   logic [1:0]        start_sel;
   logic              start_sr;
   logic              start_sl;
   logic              start_busy;

   assign free      = (state == ST_IDLE) || (state == ST_DONE);
   assign finishing = (state == ST_LOAD) || ((state == ST_RUN) && (cnt_q == CNT_W'(1)));
   assign zero_len  = (nxt_op != MODE_LOAD) && (nxt_cnt == '0);

`ifdef USR_SEQ_CMDBUF_EN
   logic              buf_full;
   logic              buf_push;
   logic              buf_pop;
   logic [1:0]        buf_op;
   logic [CNT_W-1:0]  buf_cnt;
   logic [DATA_W-1:0] buf_data;
   logic              buf_sin;

   assign cmd_ready = !buf_full;
   assign accept    = cmd_valid && cmd_ready;
   assign nxt_op    = buf_full ? buf_op   : cmd_op;
   assign nxt_cnt   = buf_full ? buf_cnt  : cmd_cnt;
   assign nxt_data  = buf_full ? buf_data : cmd_data;
   assign nxt_sin   = buf_full ? buf_sin  : cmd_sin;
   // a zero-length follower waits for the normal DONE cycle so both done pulses stay distinct
   assign take      = (buf_full || accept) && (free || (finishing && !zero_len));
   assign buf_push  = accept && !take;
   assign buf_pop   = take && buf_full;

   usr_cmd_buf #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_cmd_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (buf_push),
      .pop      (buf_pop),
      .in_op    (cmd_op),
      .in_cnt   (cmd_cnt),
      .in_data  (cmd_data),
      .in_sin   (cmd_sin),
      .full     (buf_full),
      .out_op   (buf_op),
      .out_cnt  (buf_cnt),
      .out_data (buf_data),
      .out_sin  (buf_sin)
   );
`else
   assign cmd_ready = free;
   assign accept    = cmd_valid && cmd_ready;
   assign nxt_op    = cmd_op;
   assign nxt_cnt   = cmd_cnt;
   assign nxt_data  = cmd_data;
   assign nxt_sin   = cmd_sin;
   assign take      = accept;
`endif

   // first-cycle outputs of whichever command is about to start
   always_comb begin
      start_state = ST_DONE;
      start_sel   = MODE_HOLD;
      start_sr    = 1'b0;
      start_sl    = 1'b0;
      start_busy  = 1'b0;
      if (nxt_op == MODE_LOAD) begin
         start_state = ST_LOAD;
         start_sel   = MODE_LOAD;
         start_busy  = 1'b1;
      end else if (nxt_cnt != '0) begin
         start_state = ST_RUN;
         start_sel   = nxt_op;
         start_sr    = (nxt_op == MODE_SHR) && nxt_sin;
         start_sl    = (nxt_op == MODE_SHL) && nxt_sin;
         start_busy  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt_q    <= '0;
         sel      <= MODE_HOLD;
         sr_in    <= 1'b0;
         sl_in    <= 1'b0;
         par_data <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else if (take) begin
         state <= start_state;
         cnt_q <= nxt_cnt;
         sel   <= start_sel;
         sr_in <= start_sr;
         sl_in <= start_sl;
         busy  <= start_busy;
         done  <= zero_len || finishing;
         if (nxt_op == MODE_LOAD) begin
            par_data <= nxt_data;
         end
      end else if (finishing) begin
         state <= ST_DONE;
         cnt_q <= '0;
         sel   <= MODE_HOLD;
         sr_in <= 1'b0;
         sl_in <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b1;
      end else if (state == ST_RUN) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end else begin
         state <= ST_IDLE;
         sel   <= MODE_HOLD;
         sr_in <= 1'b0;
         sl_in <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_usr_mode_sequencer.sv
// Self-checking bench for usr_mode_sequencer: directed scenarios plus random commands against a
// per-cycle schedule model of the expected outputs.
module tb_usr_mode_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [2:0] cmd_cnt = 3'd0;
   logic [3:0] cmd_data = 4'd0;
   logic       cmd_sin = 1'b0;
   logic [1:0] sel;
   logic       sr_in;
   logic       sl_in;
   logic [3:0] par_data;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] sel;
      logic       sr;
      logic       sl;
      logic       busy;
      logic       done;
      logic       ld;
      logic [3:0] par;
   } exp_t;

   exp_t       sched[$];
   logic [3:0] exp_par = 4'd0;

   always #5 clk = ~clk;

   usr_mode_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_cnt   (cmd_cnt),
      .cmd_data  (cmd_data),
      .cmd_sin   (cmd_sin),
      .sel       (sel),
      .sr_in     (sr_in),
      .sl_in     (sl_in),
      .par_data  (par_data),
      .busy      (busy),
      .done      (done)
   );

   function automatic exp_t mkEnt(logic [1:0] s, logic r, logic l, logic b, logic d, logic ld, logic [3:0] p);
      exp_t e;
      e.sel = s; e.sr = r; e.sl = l; e.busy = b; e.done = d; e.ld = ld; e.par = p;
      return e;
   endfunction

   // idle cycles are all-zero; ready whenever nothing is driving the muxes
   function automatic exp_t curExp();
      if (sched.size() == 0) return mkEnt(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      return sched[0];
   endfunction

   task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      e = curExp();
      check1("sel", 32'(sel), 32'(e.sel));
      check1("sr_in", 32'(sr_in), 32'(e.sr));
      check1("sl_in", 32'(sl_in), 32'(e.sl));
      check1("busy", 32'(busy), 32'(e.busy));
      check1("done", 32'(done), 32'(e.done));
      check1("cmd_ready", 32'(cmd_ready), 32'(!e.busy));
      check1("par_data", 32'(par_data), 32'(exp_par));
   endtask

   task automatic modelAccept(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data, input logic sin);
      if (op == 2'b11) begin
         sched.push_back(mkEnt(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, data));
      end else begin
         for (int i = 0; i < int'(cnt); i++)
            sched.push_back(mkEnt(op, (op == 2'b01) && sin, (op == 2'b10) && sin, 1'b1, 1'b0, 1'b0, 4'd0));
      end
      sched.push_back(mkEnt(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0));
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data, input logic sin);
      cmd_valid = v;
      cmd_op    = op;
      cmd_cnt   = cnt;
      cmd_data  = data;
      cmd_sin   = sin;
   endtask

   // called at a negedge: check, drive, cross the posedge, advance the model, land on the next negedge
   task automatic step(input logic v, input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data, input logic sin);
      logic acc;
      checkOutput();
      applyStimulus(v, op, cnt, data, sin);
      acc = v && !curExp().busy && rst_n;
      @(posedge clk);
      if (rst_n) begin
         if (sched.size() > 0) void'(sched.pop_front());
         if (acc) modelAccept(op, cnt, data, sin);
         if (sched.size() > 0 && sched[0].ld) exp_par = sched[0].par;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 3'd0, 4'd0, 1'b0);
   endtask

   initial begin
      $display("[TB] start");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check1("rst_sel", 32'(sel), 32'h0);
      check1("rst_busy", 32'(busy), 32'h0);
      check1("rst_done", 32'(done), 32'h0);
      check1("rst_ready", 32'(cmd_ready), 32'h1);

      step(1'b1, 2'b11, 3'd0, 4'b1010, 1'b0);
      check1("load_sel", 32'(sel), 32'h3);
      check1("load_par", 32'(par_data), 32'ha);
      idle(1);
      check1("load_done", 32'(done), 32'h1);
      check1("load_done_sel", 32'(sel), 32'h0);
      idle(1);

      step(1'b1, 2'b01, 3'd3, 4'd0, 1'b1);
      check1("shr_sel", 32'(sel), 32'h1);
      check1("shr_sr", 32'(sr_in), 32'h1);
      check1("shr_sl", 32'(sl_in), 32'h0);
      idle(3);
      check1("shr_done", 32'(done), 32'h1);
      step(1'b1, 2'b10, 3'd2, 4'd0, 1'b1);
      check1("shl_sel", 32'(sel), 32'h2);
      check1("shl_sl", 32'(sl_in), 32'h1);
      idle(2);
      check1("shl_done", 32'(done), 32'h1);
      idle(1);

      step(1'b1, 2'b10, 3'd0, 4'd0, 1'b1);
      check1("zero_done", 32'(done), 32'h1);
      check1("zero_busy", 32'(busy), 32'h0);
      step(1'b1, 2'b00, 3'd7, 4'd0, 1'b0);
      check1("hold_busy", 32'(busy), 32'h1);
      idle(6);
      check1("hold_last_busy", 32'(busy), 32'h1);
      idle(1);
      check1("hold_done", 32'(done), 32'h1);
      idle(1);

      step(1'b1, 2'b10, 3'd5, 4'd0, 1'b1);
      idle(1);
      check1("pre_rst_busy", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check1("arst_sel", 32'(sel), 32'h0);
      check1("arst_sl", 32'(sl_in), 32'h0);
      check1("arst_busy", 32'(busy), 32'h0);
      check1("arst_par", 32'(par_data), 32'h0);
      sched.delete();
      exp_par = 4'd0;
      @(negedge clk);
      idle(2);
      rst_n = 1'b1;
      check1("post_rst_ready", 32'(cmd_ready), 32'h1);
      idle(2);

      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      idle(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
